// File: rtl/pic_pkg.sv
// Shared definitions for the picture blitter: FSM encoding, default geometry, transparent key colour.
// Pure declarations; no timing or flow control of its own.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_IMG_W    = 160;
    localparam int DEF_IMG_H    = 120;
    localparam int DEF_NUM_IMG  = 3;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_XY_W     = 10;
    localparam int DEF_ROM_LAT  = 1;

    // Counter widths never collapse to zero, even for degenerate 1-wide geometries.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // KEY_COLOUR: all ones in the low w bits.
    function automatic logic [31:0] key_colour(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

endpackage

// File: rtl/pic_scan_counter.sv
// Raster col/row/address counter with last-pixel flag; registered outputs, advances one pixel per enabled clock.
// No backpressure: en is the only throttle, clear wins over en.
module pic_scan_counter
    import pic_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    localparam int ADDR_W = clog2_min1(IMG_W * IMG_H),
    localparam int COL_W  = clog2_min1(IMG_W),
    localparam int ROW_W  = clog2_min1(IMG_H)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              en,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    assign last = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));

    // Address is an incrementing counter alongside col/row, so no multiply is needed.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (en) begin
            if (last) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end else begin
                addr <= addr + 1'b1;
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pic_blitter.sv
// Frame-synchronised image blitter; first plot ROM_LAT+1 clocks after scan start, one plot per clock.
// No backpressure from the VGA side; `TRANSPARENT_EN suppresses plots whose colour equals the key.
module pic_blitter
    import pic_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int NUM_IMG  = DEF_NUM_IMG,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int XY_W     = DEF_XY_W,
    parameter int ROM_LAT  = DEF_ROM_LAT,
    localparam int ADDR_W  = clog2_min1(IMG_W * IMG_H),
    localparam int SEL_W   = clog2_min1(NUM_IMG)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         frame,
    input  logic [SEL_W-1:0]             img_sel,
    input  logic [XY_W-1:0]              x_org,
    input  logic [XY_W-1:0]              y_org,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [NUM_IMG*COLOUR_W-1:0]  rom_q,
    output logic                         busy,
    output logic                         done,
    output logic                         plot,
    output logic [XY_W-1:0]              x,
    output logic [XY_W-1:0]              y,
    output logic [COLOUR_W-1:0]          colour
);

    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam int DRN_W = clog2_min1(ROM_LAT + 1);

    state_t             state, state_nxt;
    logic               kill;
    logic               scan_en, scan_clr, scan_last;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [DRN_W-1:0]   drn_cnt;
    logic [SEL_W-1:0]   sel_q;
    logic [XY_W-1:0]    xo_q, yo_q;
    logic               dl_vld [ROM_LAT];
    logic [COL_W-1:0]   dl_col [ROM_LAT];
    logic [ROW_W-1:0]   dl_row [ROM_LAT];
    logic [COLOUR_W-1:0] pix;
    logic               pix_show;

    assign kill = abort && (state != ST_IDLE);

    pic_scan_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (scan_clr),
        .en     (scan_en),
        .col    (col),
        .row    (row),
        .addr   (rom_addr),
        .last   (scan_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        scan_en   = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ARMED;
            ST_ARMED: begin
                busy = 1'b1;
                if (frame) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                busy    = 1'b1;
                scan_en = 1'b1;
                if (scan_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Last address is still in the ROM + output register; release after it lands.
                if (drn_cnt == DRN_W'(ROM_LAT)) state_nxt = ST_DONE;
            end
            ST_DONE:  begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
        scan_clr = (state_nxt != ST_SCAN);
    end

    always_ff @(posedge clk) begin
        if (!resetn || state != ST_DRAIN) drn_cnt <= '0;
        else                              drn_cnt <= drn_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_q <= '0;
            xo_q  <= '0;
            yo_q  <= '0;
        end else if (state == ST_IDLE && start) begin
            sel_q <= img_sel;
            xo_q  <= x_org;
            yo_q  <= y_org;
        end
    end

    // Coordinates ride alongside the ROM access so they meet rom_q at the last stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                dl_vld[k] <= 1'b0;
                dl_col[k] <= '0;
                dl_row[k] <= '0;
            end
        end else begin
            dl_vld[0] <= scan_en;
            dl_col[0] <= col;
            dl_row[0] <= row;
            for (int k = 1; k < ROM_LAT; k++) begin
                dl_vld[k] <= dl_vld[k-1];
                dl_col[k] <= dl_col[k-1];
                dl_row[k] <= dl_row[k-1];
            end
            if (kill) begin
                for (int k = 0; k < ROM_LAT; k++) dl_vld[k] <= 1'b0;
            end
        end
    end

    // Out-of-range selects fall through to black.
    always_comb begin
        pix = '0;
        for (int i = 0; i < NUM_IMG; i++) begin
            if (sel_q == SEL_W'(i)) pix = rom_q[i*COLOUR_W +: COLOUR_W];
        end
    end

`ifdef TRANSPARENT_EN
    localparam logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(key_colour(COLOUR_W));
    assign pix_show = (pix != KEY_COLOUR);
`else
    assign pix_show = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            plot <= dl_vld[ROM_LAT-1] && pix_show && !kill;
            if (dl_vld[ROM_LAT-1]) begin
                x      <= xo_q + XY_W'(dl_col[ROM_LAT-1]);
                y      <= yo_q + XY_W'(dl_row[ROM_LAT-1]);
                colour <= pix;
            end
        end
    end

endmodule
